// File: rtl/copi_command_scheduler_if.sv
// rtl/copi_command_scheduler_if.sv - host/engine bus bundle for the COPI command scheduler
//
// Groups the host configuration port, the engine word-fetch port and the
// scheduler status outputs.
//   master : host + acquisition engine side (drives cfg_*, frame_done, word_req/idx)
//   slave  : scheduler side (drives word_data/valid and the status outputs)
// Parameters IDX_W and CNT_W must match the scheduler instance.
interface copi_command_scheduler_if #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 8
);
    // host configuration
    logic             cfg_wr_en;
    logic             cfg_wr_bank;
    logic [IDX_W-1:0] cfg_wr_idx;
    logic [15:0]      cfg_wr_data;
    logic             cfg_commit;
    logic             cfg_arm;
    logic [CNT_W-1:0] cfg_oneshot_count;
    // engine side
    logic             frame_done;
    logic             word_req;
    logic [IDX_W-1:0] word_idx;
    logic [15:0]      word_data;
    logic             word_valid;
    // status
    logic             active_default;
    logic             oneshot_active;
    logic             commit_pending;
    logic             sched_err;
    logic [CNT_W-1:0] oneshot_frames_left;

    modport master (
        output cfg_wr_en, cfg_wr_bank, cfg_wr_idx, cfg_wr_data,
        output cfg_commit, cfg_arm, cfg_oneshot_count,
        output frame_done, word_req, word_idx,
        input  word_data, word_valid,
        input  active_default, oneshot_active, commit_pending, sched_err,
        input  oneshot_frames_left
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_bank, cfg_wr_idx, cfg_wr_data,
        input  cfg_commit, cfg_arm, cfg_oneshot_count,
        input  frame_done, word_req, word_idx,
        output word_data, word_valid,
        output active_default, oneshot_active, commit_pending, sched_err,
        output oneshot_frames_left
    );
endinterface

// File: rtl/copi_command_scheduler.sv
// rtl/copi_command_scheduler.sv - frame-level sequencer for COPI command word lists
//
// Holds a ping-pong pair of default command lists plus an optional one-shot
// list, NUM_WORDS x 16 bits each, and picks which list the acquisition engine
// reads during each frame. List swaps and one-shot start/stop only happen on
// frame_done so the engine never sees a list change mid-frame.
//
// Optional feature macro: SCHED_ONESHOT_EN
//   defined   : one-shot bank, ARMED/ONESHOT states and the frame counter exist
//   undefined : only the two default banks; cfg_arm and one-shot writes are errors
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - copi_command_scheduler_if.slave
//          cfg_wr_en/bank/idx/data : host word write (bank 0 = inactive default,
//                                    bank 1 = one-shot)
//          cfg_commit              : swap default lists at next frame boundary
//          cfg_arm / cfg_oneshot_count : run one-shot list for N frames (0 -> 1)
//          frame_done              : end-of-frame pulse from the engine
//          word_req/word_idx       : engine word fetch
//          word_data/word_valid    : fetched word, one cycle later
//          active_default, oneshot_active, commit_pending, sched_err,
//          oneshot_frames_left     : status
module copi_command_scheduler #(
    parameter int NUM_WORDS = 35,
    parameter int IDX_W     = 6,
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    copi_command_scheduler_if.slave   bus
);

    localparam logic [IDX_W-1:0] LP_NUM = IDX_W'(NUM_WORDS);

    typedef enum logic [1:0] {
        ST_DEFAULT = 2'd0,
        ST_ARMED   = 2'd1,
        ST_ONESHOT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_active_default;
    logic             r_commit_pending;
    logic             r_sched_err;
    logic [15:0]      r_word_data;
    logic             r_word_valid;

    logic [15:0]      r_mem_d0 [NUM_WORDS];
    logic [15:0]      r_mem_d1 [NUM_WORDS];

`ifdef SCHED_ONESHOT_EN
    logic [15:0]      r_mem_os [NUM_WORDS];
    logic [CNT_W-1:0] r_frames_left;
    logic [CNT_W-1:0] r_arm_count;
    logic [CNT_W-1:0] w_frames_left_nxt;
    logic [CNT_W-1:0] w_arm_count_nxt;
    logic [CNT_W-1:0] w_arm_cnt;
`else
    logic             w_unused_cnt;
`endif

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic             w_active_nxt;
    logic             w_pending_nxt;
    logic             w_err_set;
    logic             w_wr_idx_ok;
    logic             w_rd_idx_ok;
    logic             w_serve_os;
    logic [15:0]      w_rd_word;

    assign w_wr_idx_ok = (bus.cfg_wr_idx < LP_NUM);
    assign w_rd_idx_ok = (bus.word_idx < LP_NUM);
    assign w_serve_os  = (r_state == ST_ONESHOT);

    // ------------------------------------------------------------------
    // FSM + frame-boundary control: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_DEFAULT;
            r_active_default <= 1'b0;
            r_commit_pending <= 1'b0;
            r_sched_err      <= 1'b0;
`ifdef SCHED_ONESHOT_EN
            r_frames_left    <= '0;
            r_arm_count      <= '0;
`endif
        end else begin
            r_state          <= w_state_nxt;
            r_active_default <= w_active_nxt;
            r_commit_pending <= w_pending_nxt;
            r_sched_err      <= r_sched_err | w_err_set;
`ifdef SCHED_ONESHOT_EN
            r_frames_left    <= w_frames_left_nxt;
            r_arm_count      <= w_arm_count_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM + frame-boundary control: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_active_nxt      = r_active_default;
        w_pending_nxt     = r_commit_pending;
        w_err_set         = 1'b0;
`ifdef SCHED_ONESHOT_EN
        w_frames_left_nxt = r_frames_left;
        w_arm_count_nxt   = r_arm_count;
        // a zero count still runs the one-shot list once
        w_arm_cnt         = (bus.cfg_oneshot_count == '0) ? CNT_W'(1) : bus.cfg_oneshot_count;
`endif

        if (bus.cfg_wr_en && !w_wr_idx_ok)
            w_err_set = 1'b1;
        if (bus.word_req && !w_rd_idx_ok)
            w_err_set = 1'b1;

`ifdef SCHED_ONESHOT_EN
        // the one-shot list is frozen from arm until the last one-shot frame ends
        if (bus.cfg_wr_en && bus.cfg_wr_bank && (r_state != ST_DEFAULT))
            w_err_set = 1'b1;

        case (r_state)
            ST_DEFAULT: begin
                if (bus.cfg_arm) begin
                    w_arm_count_nxt = w_arm_cnt;
                    // arm landing on a boundary starts the one-shot right away
                    if (bus.frame_done) begin
                        w_state_nxt       = ST_ONESHOT;
                        w_frames_left_nxt = w_arm_cnt;
                    end else begin
                        w_state_nxt = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (bus.cfg_arm)
                    w_err_set = 1'b1;
                if (bus.frame_done) begin
                    w_state_nxt       = ST_ONESHOT;
                    w_frames_left_nxt = r_arm_count;
                end
            end
            ST_ONESHOT: begin
                if (bus.cfg_arm)
                    w_err_set = 1'b1;
                if (bus.frame_done) begin
                    w_frames_left_nxt = r_frames_left - CNT_W'(1);
                    if (r_frames_left == CNT_W'(1))
                        w_state_nxt = ST_DEFAULT;
                end
            end
            default: begin
                w_state_nxt = ST_DEFAULT;
            end
        endcase
`else
        if (bus.cfg_wr_en && bus.cfg_wr_bank)
            w_err_set = 1'b1;
        if (bus.cfg_arm)
            w_err_set = 1'b1;
`endif

        // commit coincident with frame_done swaps at that same boundary
        if (bus.frame_done && (r_commit_pending || bus.cfg_commit)) begin
            w_active_nxt  = ~r_active_default;
            w_pending_nxt = 1'b0;
        end else if (bus.cfg_commit) begin
            w_pending_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Bank storage (not reset). Default writes target the bank that is
    // inactive before any swap on this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en && w_wr_idx_ok) begin
            if (!bus.cfg_wr_bank) begin
                if (r_active_default)
                    r_mem_d0[bus.cfg_wr_idx] <= bus.cfg_wr_data;
                else
                    r_mem_d1[bus.cfg_wr_idx] <= bus.cfg_wr_data;
            end
`ifdef SCHED_ONESHOT_EN
            else if (r_state == ST_DEFAULT) begin
                r_mem_os[bus.cfg_wr_idx] <= bus.cfg_wr_data;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Read path: bank choice uses pre-edge state, so a request on the
    // frame_done cycle still reads the ending frame's list.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_word = 16'h0000;
        if (w_rd_idx_ok) begin
`ifdef SCHED_ONESHOT_EN
            if (w_serve_os)
                w_rd_word = r_mem_os[bus.word_idx];
            else
`endif
            if (r_active_default)
                w_rd_word = r_mem_d1[bus.word_idx];
            else
                w_rd_word = r_mem_d0[bus.word_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_data  <= 16'h0000;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= bus.word_req;
            if (bus.word_req)
                r_word_data <= w_rd_word;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.word_data      = r_word_data;
    assign bus.word_valid     = r_word_valid;
    assign bus.active_default = r_active_default;
    assign bus.commit_pending = r_commit_pending;
    assign bus.sched_err      = r_sched_err;

`ifdef SCHED_ONESHOT_EN
    assign bus.oneshot_active      = w_serve_os;
    assign bus.oneshot_frames_left = r_frames_left;
`else
    assign bus.oneshot_active      = 1'b0;
    assign bus.oneshot_frames_left = '0;
    assign w_unused_cnt            = ^{bus.cfg_oneshot_count, w_serve_os};
`endif

endmodule

// File: tb/tb_copi_command_scheduler.sv
// tb/tb_copi_command_scheduler.sv - self-checking bench for copi_command_scheduler
module tb_copi_command_scheduler;

    localparam int NUM_WORDS = 35;
    localparam int IDX_W     = 6;
    localparam int CNT_W     = 8;
`ifdef SCHED_ONESHOT_EN
    localparam bit OS_EN = 1'b1;
`else
    localparam bit OS_EN = 1'b0;
`endif

    logic clk;
    logic rst;

    copi_command_scheduler_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    copi_command_scheduler #(
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: three lists, a pending-swap flag, an "armed" flag
    // and a count of one-shot frames still to serve (0 = serving default).
    logic [15:0] m_bank [3][NUM_WORDS];
    bit          m_active, m_pending, m_err, m_armed, m_valid;
    int          m_arm_n, m_left;
    logic [15:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_pending = 0; m_err = 0; m_armed = 0;
        m_valid = 0; m_arm_n = 0; m_left = 0; m_data = 16'h0000;
    endtask

    task automatic model_step();
        bit in_os;
        bit armed;
        int cnt;
        in_os = (m_left > 0);
        armed = m_armed;
        if (bus.word_req) begin
            if (int'(bus.word_idx) < NUM_WORDS)
                m_data = in_os ? m_bank[2][bus.word_idx] : m_bank[int'(m_active)][bus.word_idx];
            else begin
                m_data = 16'h0000;
                m_err  = 1;
            end
        end
        m_valid = bus.word_req;
        if (bus.cfg_wr_en) begin
            if (int'(bus.cfg_wr_idx) >= NUM_WORDS)            m_err = 1;
            else if (!bus.cfg_wr_bank)                        m_bank[int'(!m_active)][bus.cfg_wr_idx] = bus.cfg_wr_data;
            else if (!OS_EN || armed || in_os)                m_err = 1;
            else                                              m_bank[2][bus.cfg_wr_idx] = bus.cfg_wr_data;
        end
        cnt = (bus.cfg_oneshot_count == 0) ? 1 : int'(bus.cfg_oneshot_count);
        if (bus.cfg_arm) begin
            if (!OS_EN || armed || in_os) m_err = 1;
            else begin armed = 1; m_arm_n = cnt; end
        end
        if (bus.frame_done) begin
            if (in_os) m_left = m_left - 1;
            else if (armed) begin m_left = m_arm_n; armed = 0; end
            if (m_pending || bus.cfg_commit) begin
                m_active  = !m_active;
                m_pending = 0;
            end
        end else if (bus.cfg_commit) begin
            m_pending = 1;
        end
        m_armed = armed;
    endtask

    task automatic compare_all();
        chk("word_data",      bus.word_data,           m_data);
        chk("word_valid",     bus.word_valid,          m_valid);
        chk("active_default", bus.active_default,      m_active);
        chk("commit_pending", bus.commit_pending,      m_pending);
        chk("sched_err",      bus.sched_err,           m_err);
        chk("oneshot_active", bus.oneshot_active,      (m_left > 0));
        chk("frames_left",    bus.oneshot_frames_left, m_left);
    endtask

    task automatic idle();
        bus.cfg_wr_en = 0; bus.cfg_wr_bank = 0; bus.cfg_wr_idx = '0; bus.cfg_wr_data = '0;
        bus.cfg_commit = 0; bus.cfg_arm = 0; bus.cfg_oneshot_count = '0;
        bus.frame_done = 0; bus.word_req = 0; bus.word_idx = '0;
    endtask

    // model sees pre-edge inputs, then DUT is sampled 1 ns after the edge
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        idle();
    endtask

    task automatic wr(input bit bank, input int idx, input logic [15:0] data);
        bus.cfg_wr_en = 1; bus.cfg_wr_bank = bank; bus.cfg_wr_idx = IDX_W'(idx); bus.cfg_wr_data = data;
        step();
    endtask

    task automatic rd(input int idx);
        bus.word_req = 1; bus.word_idx = IDX_W'(idx);
        step();
    endtask

    task automatic frame();
        bus.frame_done = 1;
        step();
    endtask

    task automatic arm(input int n);
        bus.cfg_arm = 1; bus.cfg_oneshot_count = CNT_W'(n);
        step();
    endtask

    task automatic async_reset();
        #2 rst = 1;
        #1;
        model_reset();
        chk("rst_word_data",   bus.word_data,           0);
        chk("rst_word_valid",  bus.word_valid,          0);
        chk("rst_active",      bus.active_default,      0);
        chk("rst_os_active",   bus.oneshot_active,      0);
        chk("rst_pending",     bus.commit_pending,      0);
        chk("rst_err",         bus.sched_err,           0);
        chk("rst_frames_left", bus.oneshot_frames_left, 0);
        #2 rst = 0;
    endtask

    initial begin
        int fpos;
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 rst = 0;
        step();

        // write default list (lands in bank 1), commit, swap
        for (int i = 0; i < NUM_WORDS; i++) wr(0, i, 16'h1000 + 16'(i));
        bus.cfg_commit = 1; step();
        chk("tp1_pending", bus.commit_pending, 1);
        frame();
        chk("tp1_active", bus.active_default, 1);
        rd(5);
        chk("tp1_data",  bus.word_data, 16'h1005);
        chk("tp1_valid", bus.word_valid, 1);
        step();
        chk("tp1_hold",  bus.word_data, 16'h1005);

        // fill the other default bank and the one-shot bank
        for (int i = 0; i < NUM_WORDS; i++) wr(0, i, 16'h2000 + 16'(i));
        for (int i = 0; i < NUM_WORDS; i++) wr(1, i, (i == 0) ? 16'hA5A5 : 16'h3000 + 16'(i));

        // one-shot for 3 frames
        arm(3);
        chk("tp2_armed_os", bus.oneshot_active, 0);
        rd(0);
        chk("tp2_armed_data", bus.word_data, 16'h1000);
        frame();
        for (int f = 0; f < 3; f++) begin
            rd(0);
            chk("tp2_os_data", bus.word_data, OS_EN ? 16'hA5A5 : 16'h1000);
            chk("tp2_left", bus.oneshot_frames_left, OS_EN ? 3 - f : 0);
            frame();
        end
        rd(0);
        chk("tp2_back_data", bus.word_data, 16'h1000);
        chk("tp2_back_os",   bus.oneshot_active, 0);

        // count 0 runs exactly one frame
        arm(0);
        frame();
        chk("tp3_left", bus.oneshot_frames_left, OS_EN ? 1 : 0);
        rd(0);
        chk("tp3_data", bus.word_data, OS_EN ? 16'hA5A5 : 16'h1000);
        frame();
        rd(0);
        chk("tp3_back", bus.word_data, 16'h1000);

        // commit + arm + read all on the frame_done cycle
        bus.cfg_commit = 1; bus.cfg_arm = 1; bus.cfg_oneshot_count = 8'd2;
        bus.frame_done = 1; bus.word_req = 1; bus.word_idx = '0;
        step();
        chk("tp4_old_word", bus.word_data, 16'h1000);
        chk("tp4_active",   bus.active_default, 0);
        chk("tp4_pending",  bus.commit_pending, 0);
        chk("tp4_left",     bus.oneshot_frames_left, OS_EN ? 2 : 0);
        rd(0);
        chk("tp4_os_word",  bus.word_data, OS_EN ? 16'hA5A5 : 16'h2000);
        frame();
        frame();
        rd(0);
        chk("tp4_new_def",  bus.word_data, 16'h2000);

        // error cases
        rd(40);
        chk("tp5_oob_data", bus.word_data, 0);
        chk("tp5_err",      bus.sched_err, 1);
        arm(2);
        arm(2);
        frame();
        wr(1, 1, 16'hBEEF);
        rd(1);
        chk("tp5_drop",     bus.word_data, OS_EN ? 16'h3001 : 16'h2001);
        frame();
        frame();
        chk("tp5_err_stay", bus.sched_err, 1);

        // reset in the middle of a one-shot
        arm(3);
        frame();
        frame();
        chk("tp6_left", bus.oneshot_frames_left, OS_EN ? 2 : 0);
        async_reset();
        rd(0);
        chk("tp6_def0", bus.word_data, 16'h2000);

        // randomized traffic against the model
        fpos = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.frame_done = (fpos == NUM_WORDS - 1);
            fpos = (fpos == NUM_WORDS - 1) ? 0 : fpos + 1;
            bus.word_req = ($urandom % 3) != 0;
            bus.word_idx = IDX_W'(($urandom % 120 == 0) ? 35 + $urandom % 29 : $urandom % 35);
            if ($urandom % 4 == 0) begin
                bus.cfg_wr_en   = 1;
                bus.cfg_wr_bank = 1'($urandom % 2);
                bus.cfg_wr_idx  = IDX_W'(($urandom % 80 == 0) ? 35 + $urandom % 29 : $urandom % 35);
                bus.cfg_wr_data = 16'($urandom);
            end
            bus.cfg_commit = ($urandom % 40) == 0;
            if ($urandom % 60 == 0) begin
                bus.cfg_arm = 1;
                bus.cfg_oneshot_count = CNT_W'($urandom % 4);
            end
            step();
            if ($urandom % 400 == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
